// File: rtl/dtree_pkg.sv
// Shared types and helpers for the decision-tree walk controller.
// Covers the walk state encoding, the child-present bit positions and the heap child index.
package dtree_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Child-present flags occupy the two top bits of a node word.
  function automatic int unsigned child_l_bit(input int unsigned depth);
    return depth - 2;
  endfunction

  function automatic int unsigned child_r_bit(input int unsigned depth);
    return depth - 1;
  endfunction

  // Heap-order child index: 2*node + 1 + dir, computed without truncation.
  function automatic int unsigned heap_child(input int unsigned node, input logic dir);
    return 2 * node + 1 + 32'(dir);
  endfunction

endpackage

// File: rtl/dtree_walk_ctrl_eval_timer.sv
// Watchdog for the evaluator handshake.
// expired_c rises on the TIMEOUT-th consecutive enabled cycle after a clear.
module dtree_eval_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_c = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dtree_walk_ctrl.sv
// Decision-tree walk sequencer: fetches heap-ordered node words, hands them to the
// external evaluator, follows the returned direction to a leaf, and arbitrates host writes.
module dtree_walk_ctrl
  import dtree_pkg::*;
#(
  parameter  int unsigned DEPTH        = 24,
  parameter  int unsigned WORDS        = 8,
  parameter  int unsigned EVAL_TIMEOUT = 255,
  localparam int unsigned AW           = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    leaf_node,
  output logic             leaf_dir,
  output logic             error,
  output logic             mem_ce,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [DEPTH-1:0] mem_d_out,
  output logic             mem_d_oe,
  input  logic [DEPTH-1:0] mem_d_in,
  output logic [DEPTH-1:0] node_word,
  output logic             node_valid,
  input  logic             eval_valid,
  input  logic             eval_dir,
  input  logic             cfg_req,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [DEPTH-1:0] cfg_data,
  output logic             cfg_ack
);

  localparam int unsigned CHILD_L_BIT = child_l_bit(DEPTH);
  localparam int unsigned CHILD_R_BIT = child_r_bit(DEPTH);
  localparam int unsigned CIW         = AW + 2;

  state_e state_q, state_d;

  logic [AW-1:0]    node_q, node_d;
  logic             dir_q, dir_d;
  logic             pending_q, pending_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AW-1:0]    leaf_node_q, leaf_node_d;
  logic             leaf_dir_q, leaf_dir_d;
  logic             error_q, error_d;
  logic             mem_ce_q, mem_ce_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_a_q, mem_a_d;
  logic [DEPTH-1:0] mem_d_out_q, mem_d_out_d;
  logic             mem_d_oe_q, mem_d_oe_d;
  logic [DEPTH-1:0] node_word_q, node_word_d;
  logic             node_valid_q, node_valid_d;
  logic             cfg_ack_q, cfg_ack_d;

  logic           tmo_expired_c;
  logic           cfg_take_c;
  logic           walk_go_c;
  logic           eval_tmo_c;
  logic [CIW-1:0] child_c;
  logic           present_c;
  logic           child_oob_c;

  dtree_eval_timer #(
    .TIMEOUT (EVAL_TIMEOUT)
  ) u_eval_timer (
    .clk       (clk),
    .rst       (reset),
    .clr       (state_q != ST_EVAL),
    .en        (state_q == ST_EVAL),
    .expired_c (tmo_expired_c)
  );

  // The ack cycle still sees the host's held request; gating on cfg_ack_q avoids a repeat write.
  assign cfg_take_c  = (state_q == ST_IDLE) && cfg_req && !cfg_ack_q;
  assign walk_go_c   = (state_q == ST_IDLE) && !cfg_take_c && (pending_q || start);
  assign eval_tmo_c  = (state_q == ST_EVAL) && !eval_valid && tmo_expired_c;
  assign child_c     = CIW'(heap_child(32'(node_q), dir_q));
  assign present_c   = dir_q ? node_word_q[CHILD_R_BIT] : node_word_q[CHILD_L_BIT];
  assign child_oob_c = (child_c >= CIW'(WORDS));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (walk_go_c) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_EVAL;
      ST_EVAL: begin
        if (eval_valid)      state_d = ST_STEP;
        else if (eval_tmo_c) state_d = ST_DONE;
      end
      ST_STEP: begin
        if (!present_c || child_oob_c) state_d = ST_DONE;
        else                           state_d = ST_FETCH;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered on the transition it belongs to.
  always_comb begin
    node_d       = node_q;
    dir_d        = dir_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    leaf_node_d  = leaf_node_q;
    leaf_dir_d   = leaf_dir_q;
    error_d      = error_q;
    mem_ce_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_a_d      = mem_a_q;
    mem_d_out_d  = '0;
    node_word_d  = node_word_q;
    node_valid_d = 1'b0;
    cfg_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_take_c) begin
          mem_ce_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_a_d     = cfg_addr;
          mem_d_out_d = cfg_data;
          cfg_ack_d   = 1'b1;
          pending_d   = pending_q | start;
        end else if (walk_go_c) begin
          pending_d = 1'b0;
          node_d    = '0;
          busy_d    = 1'b1;
          mem_ce_d  = 1'b1;
          mem_a_d   = '0;
        end
      end
      ST_WAIT: begin
        node_word_d  = mem_d_in;
        node_valid_d = 1'b1;
      end
      ST_EVAL: begin
        if (eval_valid) begin
          dir_d = eval_dir;
        end else if (eval_tmo_c) begin
          error_d     = 1'b1;
          leaf_node_d = node_q;
          leaf_dir_d  = 1'b0;
          done_d      = 1'b1;
        end
      end
      ST_STEP: begin
        if (!present_c || child_oob_c) begin
          error_d     = present_c;
          leaf_node_d = node_q;
          leaf_dir_d  = dir_q;
          done_d      = 1'b1;
        end else begin
          node_d   = child_c[AW-1:0];
          mem_ce_d = 1'b1;
          mem_a_d  = child_c[AW-1:0];
        end
      end
      ST_DONE: busy_d = 1'b0;
      default: ;
    endcase
    mem_d_oe_d = mem_ce_d & mem_we_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      node_q       <= '0;
      dir_q        <= 1'b0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      leaf_node_q  <= '0;
      leaf_dir_q   <= 1'b0;
      error_q      <= 1'b0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_d_out_q  <= '0;
      mem_d_oe_q   <= 1'b0;
      node_word_q  <= '0;
      node_valid_q <= 1'b0;
      cfg_ack_q    <= 1'b0;
    end else begin
      node_q       <= node_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      leaf_node_q  <= leaf_node_d;
      leaf_dir_q   <= leaf_dir_d;
      error_q      <= error_d;
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_a_q      <= mem_a_d;
      mem_d_out_q  <= mem_d_out_d;
      mem_d_oe_q   <= mem_d_oe_d;
      node_word_q  <= node_word_d;
      node_valid_q <= node_valid_d;
      cfg_ack_q    <= cfg_ack_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign leaf_node  = leaf_node_q;
  assign leaf_dir   = leaf_dir_q;
  assign error      = error_q;
  assign mem_ce     = mem_ce_q;
  assign mem_we     = mem_we_q;
  assign mem_a      = mem_a_q;
  assign mem_d_out  = mem_d_out_q;
  assign mem_d_oe   = mem_d_oe_q;
  assign node_word  = node_word_q;
  assign node_valid = node_valid_q;
  assign cfg_ack    = cfg_ack_q;

endmodule

// File: doc/dtree_walk_ctrl.md
Name: dtree_walk_ctrl

Overview:
- Sequencer for the decision-tree coefficient memory (DEPTH-bit words, WORDS entries, 1-cycle registered read, shared bidirectional data bus).
- Walks the tree from root node 0 in heap order. Each node word is presented to the external hyperplane evaluator, which returns a branch direction; the walk stops at a leaf.
- Also arbitrates host configuration writes into the same memory. Writes are accepted only between walks.

Parameters:
- DEPTH, 24, memory word width; child-present bits are [DEPTH-1] (right) and [DEPTH-2] (left).
- WORDS, 8, number of tree nodes; AW = $clog2(WORDS).
- EVAL_TIMEOUT, 255, max cycles to wait for eval_valid before flagging error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  1-cycle pulse requesting a tree walk
- busy  out  1  high from walk acceptance to done
- done  out  1  1-cycle pulse at walk end
- leaf_node  out  AW  node where the walk terminated
- leaf_dir  out  1  direction taken at the terminating node
- error  out  1  valid with done; child index >= WORDS or eval timeout
- mem_ce  out  1  memory chip enable
- mem_we  out  1  memory write enable
- mem_a  out  AW  memory address
- mem_d_out  out  DEPTH  write data, driven onto bus only when mem_ce&mem_we
- mem_d_oe  out  1  = mem_ce&mem_we; top-level tristate control
- mem_d_in  in  DEPTH  bus read value
- node_word  out  DEPTH  captured node word for evaluator
- node_valid  out  1  1-cycle pulse; node_word is valid
- eval_valid  in  1  evaluator result strobe
- eval_dir  in  1  0 = left, 1 = right
- cfg_req  in  1  host write request (level, held until ack)
- cfg_addr  in  AW  host write address
- cfg_data  in  DEPTH  host write data
- cfg_ack  out  1  1-cycle pulse; write performed this cycle

Behaviour:
- Reset (async): state IDLE, node=0, pending=0. All outputs 0, including mem_ce, mem_we, mem_d_oe, node_word and leaf regs.
- States: IDLE, FETCH, WAIT, EVAL, STEP, DONE.
- IDLE:
  - cfg_req has priority. Assert mem_ce=mem_we=1, mem_a=cfg_addr, mem_d_out=cfg_data and cfg_ack=1 in the same cycle, then stay IDLE.
  - start is latched into pending. If pending or start is set and cfg_req=0: clear pending, node<=0, busy<=1, go to FETCH.
  - start while busy is ignored and not queued.
  - cfg_req while busy stalls with no ack until IDLE.
- FETCH: mem_ce=1, mem_we=0, mem_a=node, go to WAIT.
- WAIT: the memory registered mem_d_in at the FETCH edge. Capture node_word<=mem_d_in, pulse node_valid next cycle, go to EVAL.
- EVAL:
  - Wait for eval_valid. Latch dir=eval_dir and go to STEP.
  - A cycle counter reaching EVAL_TIMEOUT without eval_valid sets error, leaf_node=node, leaf_dir=0, and goes to DONE.
  - eval_valid outside EVAL is ignored.
- STEP:
  - child = 2*node+1+dir, computed at AW+2 bits with no truncation.
  - If present bit for dir (node_word[DEPTH-2+dir]) is 0: leaf. leaf_node=node, leaf_dir=dir, error=0, go to DONE.
  - Else if child >= WORDS: error=1, leaf_node=node, leaf_dir=dir, go to DONE.
  - Else node<=child[AW-1:0], go to FETCH.
- DONE: done=1 for one cycle, busy<=0, go to IDLE. leaf_node, leaf_dir and error hold until the next walk's DONE.
- Latency per internal node: FETCH+WAIT+EVAL(>=1)+STEP = 4 cycles minimum. Root-leaf walk: start to done = 6 cycles.
- mem_d_oe is never high outside a cfg write. This guarantees no bus contention with the memory's read drive.
- Reset mid-walk returns to IDLE immediately. There is no done pulse and no partial write.

Decomposition:
- Shared package dtree_pkg: state encoding, bit-position constants CHILD_L_BIT/CHILD_R_BIT (as functions of DEPTH), and a heap-child index function.
- One natural sub-module: dtree_eval_timer, the EVAL_TIMEOUT watchdog counter with clear/enable/expired.

Test Plan:
- Load via cfg: write node0 = 0xC00000 (both children), node2 = 0x000000. Start; evaluator returns dir=1 at node0 and dir=0 at node2 → done with leaf_node=2, leaf_dir=0, error=0. Check mem_a sequence 0,2 and cfg_ack once per write.
- Node0 = 0x000000. Start, evaluator dir=1 1 cycle after node_valid → done exactly 6 cycles after start, leaf_node=0, leaf_dir=1.
- Nodes 0,1,3 all 0xC00000, dirs 0,0,1 → child 8 >= WORDS → error=1, leaf_node=3, leaf_dir=1.
- Start, then cfg_req asserted mid-walk → cfg_ack withheld and mem_d_oe stays 0 until after done; write lands in the first IDLE cycle. Same-cycle start+cfg_req in IDLE → write first, walk begins next cycle.
- Evaluator never responds → done and error after EVAL_TIMEOUT cycles in EVAL. Assert reset during EVAL → all outputs 0 asynchronously, no done pulse; a new start then walks normally.
